// File: rtl/adder_share_pkg.sv
// Shared types and helpers for the adder-sharing arbiter: default latency,
// id-width helper and the response-entry layout for the default configuration.
package adder_share_pkg;

  localparam int DEFAULT_LAT   = 2;
  localparam int DEFAULT_NREQ  = 4;
  localparam int DEFAULT_WIDTH = 4;

  function automatic int id_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  localparam int DEFAULT_IDW = id_width(DEFAULT_NREQ);

  typedef struct packed {
    logic [DEFAULT_IDW-1:0]   id;
    logic [DEFAULT_WIDTH-1:0] sum;
    logic                     cout;
  } rsp_entry_t;

endpackage

// File: rtl/adder_share_rr_arbiter.sv
// Combinational round-robin grant: search starts at ptr and wraps upward,
// first valid requester wins. The pointer register lives in the parent.
module adder_share_rr_arbiter
  import adder_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  ptr,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  winner,
  output logic            found
);

  int idx;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (enable && !found && req_valid[idx]) begin
        found       = 1'b1;
        winner      = IDW'(idx);
        grant[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one fixed-latency registered adder among NREQ requesters: round-robin
// issue, id tag pipeline matching the adder latency, credit-limited response FIFO.
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int LAT   = DEFAULT_LAT,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  input  logic [WIDTH-1:0]         add_sum,
  input  logic                     add_cout,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [id_width(NREQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout
);

  localparam int IDW  = id_width(NREQ);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] sum;
    logic             cout;
  } entry_t;

  logic [WIDTH-1:0] op_a [NREQ];
  logic [WIDTH-1:0] op_b [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign op_a[gi] = req_a[gi*WIDTH +: WIDTH];
      assign op_b[gi] = req_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  logic [IDW-1:0]  ptr_q, ptr_d, winner;
  logic            grant_any, enable;
  logic [CNTW-1:0] count_q, count_d, inflight;
  logic [LAT-1:0]  tag_vld_q;
  logic [IDW-1:0]  tag_id_q [LAT];
  entry_t          mem_q [DEPTH];
  entry_t          head;
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic            push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int k = 0; k < LAT; k++) inflight = inflight + CNTW'(tag_vld_q[k]);
  end

  // Credit uses registered occupancy only, so a pop frees its slot next cycle.
  assign enable = !rst && ((32'(count_q) + 32'(inflight)) < 32'(DEPTH));

  adder_share_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .enable    (enable),
    .grant     (req_ready),
    .winner    (winner),
    .found     (grant_any)
  );

  assign add_a = grant_any ? op_a[winner] : '0;
  assign add_b = grant_any ? op_b[winner] : '0;

  assign ptr_d = !grant_any ? ptr_q :
                 (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);

  assign push      = tag_vld_q[LAT-1];
  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign head      = mem_q[rd_ptr_q];
  assign rsp_id    = rsp_valid ? head.id   : '0;
  assign rsp_sum   = rsp_valid ? head.sum  : '0;
  assign rsp_cout  = rsp_valid ? head.cout : 1'b0;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNTW'(1);
    else if (!push && pop) count_d = count_q - CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      tag_vld_q <= '0;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      for (int k = 0; k < LAT; k++) tag_id_q[k] <= '0;
    end else begin
      ptr_q        <= ptr_d;
      count_q      <= count_d;
      tag_vld_q[0] <= grant_any;
      tag_id_q[0]  <= winner;
      for (int k = 1; k < LAT; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_id_q[k]  <= tag_id_q[k-1];
      end
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // Storage array carries no reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{id: tag_id_q[LAT-1], sum: add_sum, cout: add_cout};
  end

endmodule

// File: doc/adder_share_arbiter.md
# adder_share_arbiter

Shares one registered prefix-adder instance (input-register + output-register wrapper, fixed 2-cycle latency) among NREQ requesters. Round-robin arbitration picks one operand pair per cycle, drives the adder, and tracks requester IDs through the adder pipeline. Results are tagged and buffered in a small response FIFO with valid/ready backpressure. Issue is credit-limited, so no result is ever dropped.

## Interface
- NREQ, 4: number of requesters (≥2).
- WIDTH, 4: operand/sum width.
- LAT, 2: adder latency in cycles, from operands driven to add_sum/add_cout valid.
- DEPTH, 4: response FIFO entries (≥LAT).
- clk  in  1  sole clock; all state on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*WIDTH  operand A; requester i at bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B, same packing.
- add_a  out  WIDTH  operand A to adder.
- add_b  out  WIDTH  operand B to adder.
- add_sum  in  WIDTH  adder sum.
- add_cout  in  1  adder carry-out.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer accept.
- rsp_id  out  clog2(NREQ)  index of the originating requester.
- rsp_sum  out  WIDTH  result sum.
- rsp_cout  out  1  result carry-out.

## Operation
- Accept condition: req_valid[i] && req_ready[i].
- req_ready is combinational from req_valid, ptr and credit. At most one bit is set.
- credit = DEPTH − fifo_count − inflight, computed from registered counts only.
  - A FIFO pop in the current cycle frees its credit in the next cycle.
  - credit == 0 forces req_ready = 0.
- Round-robin: search starts at index ptr and wraps upward. The first valid requester wins.
  - On accept, ptr ← (winner+1) mod NREQ. Example: NREQ−1 wraps to 0.
  - With no accept, ptr holds.
- add_a/add_b carry the winner's operands in the accept cycle. They are 0 when there is no accept.
- Tag pipeline: LAT stages of {valid, id}. Stage 0 loads {accept, winner} each cycle.
- When last-stage valid is set, {id, add_sum, add_cout} is pushed into the FIFO at the end of that cycle. add_sum and add_cout are ignored when last-stage valid is clear.
- inflight = number of set valid bits in the tag pipeline.
- FIFO is show-ahead. rsp_* are driven from the head entry; rsp_valid = (fifo_count ≠ 0).
  - Pop happens on rsp_valid && rsp_ready.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Overflow cannot occur by construction. A bench assertion must check this.
- Results pass through bit-exact: WIDTH-bit sum plus separate carry, no saturation. Example: 4'hF + 4'h1 gives sum 0, cout 1.
- Response ordering equals grant ordering.

## Timing
- Accept in cycle t: add_a/add_b are valid in cycle t, and the result is pushed at the end of cycle t+LAT.
- rsp_valid rises no earlier than cycle t+LAT+1. Minimum request-to-response latency is LAT+1 = 3 cycles.
- Throughput is one accept per cycle while credit > 0 and rsp_ready stays high.
- Reset state (rst high sampled at a clock edge):
  - ptr = 0, tag valids = 0, FIFO empty.
  - rsp_valid = 0; rsp_id/rsp_sum/rsp_cout = 0.
- While rst is high, req_ready = 0 and add_a/add_b = 0.
- Reset mid-operation: in-flight and buffered results are discarded. Adder outputs arriving in the following LAT cycles are ignored because the tag valids are clear.
- Simultaneous events:
  - Accept, push and pop may all occur in one cycle, and all counters update consistently.
  - A requester dropping req_valid is legal. The arbiter re-evaluates every cycle.

## Structure
- Package adder_share_pkg holds:
  - a localparam for default LAT;
  - an id-width function (clog2 of NREQ);
  - the packed response-entry struct {id, sum, cout}.
- One sub-module: adder_share_rr_arbiter.
  - Combinational grant from {req_valid, ptr, enable}.
  - Outputs a one-hot grant plus the winner index.
  - ptr register lives in the parent.
- The FIFO and tag pipeline are inline in the parent.
- The bench connects a registered prefix-adder wrapper instance, with LAT=2, to add_*.

## Test plan
- **Single request.** Reset, then req_valid[2]=1 with a=4'h3, b=4'h5.
  - req_ready[2]=1 in the same cycle.
  - rsp_valid 3 cycles later with id=2, sum=4'h8, cout=0.
- **Carry.** Requester 0 sends a=4'hF, b=4'h1 → response sum=0, cout=1.
- **Round-robin fairness.** All four requesters valid continuously, rsp_ready=1.
  - Grants go 0,1,2,3,0,… with one per cycle.
  - Responses return in the same id order.
- **Backpressure.** rsp_ready=0 with all requesters valid.
  - Exactly DEPTH=4 accepts occur, then req_ready=0.
  - Raising rsp_ready for 1 cycle allows exactly 1 new accept, one cycle later.
  - No FIFO overflow.
- **Reset mid-operation.** Issue 2 requests, then assert rst for 1 cycle on the cycle after the second accept.
  - No rsp_valid ever appears for those requests.
  - ptr restarts at 0: the next grant goes to the lowest valid requester.
